// File: rtl/seven_segment_scanner.sv
// Time-multiplexed scanner for a common-anode hex display sharing one decoder.
// Display data is double-buffered and only swapped in at a frame boundary.
module seven_segment_scanner #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 50000,
  parameter int BLANK_CYC  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_valid,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  output logic                    load_ready,
  input  logic                    lz_en,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic [3:0]              nibble,
  output logic                    blank,
  output logic                    frame_done
);

  localparam int DW      = 4 * NUM_DIGITS;
  localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IW      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    SHOW  = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t                r_state, w_state_nx;
  logic [IW-1:0]         r_idx, w_idx_nx;
  logic [CW-1:0]         r_cnt, w_cnt_nx;
  logic                  r_first, w_first_nx;
  logic [DW-1:0]         r_disp, w_disp_nx;
  logic [DW-1:0]         r_pend, w_pend_nx;
  logic                  r_pend_full, w_pend_full_nx;
  logic [NUM_DIGITS-1:0] r_digit_sel, w_digit_sel_nx;
  logic [3:0]            r_nibble, w_nibble_nx;
  logic                  r_blank, w_blank_nx;
  logic                  r_frame_done, w_frame_done_nx;
  logic                  w_boundary;

  // Digit idx is suppressed when it and every more-significant nibble are zero.
  function automatic logic lz_suppress(input logic [DW-1:0] disp,
                                       input logic [IW-1:0] idx,
                                       input logic          en);
    logic upper_zero;
    upper_zero = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ((i >= int'(idx)) && (disp[4*i +: 4] != 4'h0)) begin
        upper_zero = 1'b0;
      end else begin
        upper_zero = upper_zero;
      end
    end
    return en && (idx != '0) && upper_zero;
  endfunction

  // Next-state, double-buffer handshake and next output values.
  always_comb begin
    w_state_nx      = r_state;
    w_idx_nx        = r_idx;
    w_cnt_nx        = r_cnt;
    w_first_nx      = r_first;
    w_disp_nx       = r_disp;
    w_pend_nx       = r_pend;
    w_pend_full_nx  = r_pend_full;
    w_digit_sel_nx  = '1;
    w_nibble_nx     = r_nibble;
    w_blank_nx      = 1'b1;
    w_frame_done_nx = 1'b0;

    // The very first BLANK after reset counts as a boundary and keeps idx at 0.
    w_boundary = (r_state == BLANK) && (r_cnt == BLANK_LAST) &&
                 (r_first || (r_idx == IDX_LAST));

    case (r_state)
      SHOW: begin
        if (r_cnt == DWELL_LAST) begin
          w_state_nx = BLANK;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      BLANK: begin
        if (r_cnt == BLANK_LAST) begin
          w_state_nx = SHOW;
          w_cnt_nx   = '0;
          w_first_nx = 1'b0;
          w_idx_nx   = w_boundary ? '0 : (r_idx + 1'b1);
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = BLANK;
        w_cnt_nx   = '0;
      end
    endcase

    if (w_boundary && r_pend_full) begin
      w_disp_nx      = r_pend;
      w_pend_full_nx = 1'b0;
    end else if (load_valid && !r_pend_full) begin
      w_pend_nx      = load_data;
      w_pend_full_nx = 1'b1;
    end else begin
      w_pend_full_nx = r_pend_full;
    end

    // Outputs are registered from the next state so they line up with it.
    if (w_state_nx == SHOW) begin
      w_digit_sel_nx = ~(NUM_DIGITS'(1) << w_idx_nx);
      w_nibble_nx    = w_disp_nx[4*w_idx_nx +: 4];
      w_blank_nx     = lz_suppress(w_disp_nx, w_idx_nx, lz_en);
    end else begin
      w_digit_sel_nx = '1;
      w_nibble_nx    = r_nibble;
      w_blank_nx     = 1'b1;
    end

    w_frame_done_nx = (w_state_nx == BLANK) && (w_cnt_nx == BLANK_LAST) &&
                      (w_first_nx || (w_idx_nx == IDX_LAST));
  end

  // State, buffers and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_first      <= 1'b1;
      r_disp       <= '0;
      r_pend       <= '0;
      r_pend_full  <= 1'b0;
      r_digit_sel  <= '1;
      r_nibble     <= 4'h0;
      r_blank      <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_idx        <= w_idx_nx;
      r_cnt        <= w_cnt_nx;
      r_first      <= w_first_nx;
      r_disp       <= w_disp_nx;
      r_pend       <= w_pend_nx;
      r_pend_full  <= w_pend_full_nx;
      r_digit_sel  <= w_digit_sel_nx;
      r_nibble     <= w_nibble_nx;
      r_blank      <= w_blank_nx;
      r_frame_done <= w_frame_done_nx;
    end
  end

  assign load_ready = ~r_pend_full;
  assign digit_sel  = r_digit_sel;
  assign nibble     = r_nibble;
  assign blank      = r_blank;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: directed steps plus random loads, checked
// each cycle against a timing/arithmetic model of the display schedule.
module tb_seven_segment_scanner;

  localparam int N = 4;
  localparam int D = 3;
  localparam int B = 2;
  localparam int S = D + B;
  localparam int F = N * S;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [15:0]   load_data;
  logic          load_ready;
  logic          lz_en;
  logic [N-1:0]  digit_sel;
  logic [3:0]    nibble;
  logic          blank;
  logic          frame_done;

  int            k;
  logic [15:0]   m_disp;
  logic [15:0]   m_pend;
  logic          m_full;
  logic          m_lz;
  logic [3:0]    m_last;
  int            n_checks;
  int            n_pass;
  int            n_fail;

  seven_segment_scanner #(.NUM_DIGITS(N), .DWELL(D), .BLANK_CYC(B)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .lz_en      (lz_en),
    .digit_sel  (digit_sel),
    .nibble     (nibble),
    .blank      (blank),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  // Cycle kk counts rising edges since reset release; kk=0 is the reset state.
  function automatic bit fd(input int kk);
    return (kk == B - 1) || ((kk >= B) && (((kk - B) % F) == F - 1));
  endfunction

  function automatic bit show(input int kk);
    return (kk >= B) && (((kk - B) % S) < D);
  endfunction

  function automatic int slot(input int kk);
    return ((kk - B) % F) / S;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h at cycle %0d", tag, obs, exp, k);
    end
  endtask

  task automatic check_outputs();
    bit         sh;
    int         sl;
    logic [3:0] exp_sel;
    logic [3:0] exp_nib;
    logic       exp_blank;
    sh = show(k);
    sl = sh ? slot(k) : 0;
    exp_sel   = sh ? ~(4'b0001 << sl) : 4'hF;
    exp_nib   = sh ? 4'(m_disp >> (4 * sl)) : m_last;
    exp_blank = sh ? (m_lz && (sl > 0) && ((m_disp >> (4 * sl)) == 16'h0)) : 1'b1;
    if (sh) m_last = exp_nib;
    chk("digit_sel", 16'(digit_sel), 16'(exp_sel));
    chk("nibble", 16'(nibble), 16'(exp_nib));
    chk("blank", 16'(blank), 16'(exp_blank));
    chk("frame_done", 16'(frame_done), 16'(fd(k)));
    chk("load_ready", 16'(load_ready), 16'(!m_full));
  endtask

  // One rising edge: advance the model with the inputs the DUT sampled.
  task automatic cycle();
    bit acc;
    @(posedge clk);
    acc  = load_valid && !m_full;
    m_lz = lz_en;
    if (fd(k) && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (acc) begin
      m_pend = load_data;
      m_full = 1'b1;
    end
    k++;
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Hold valid until the transfer happens, bounded.
  task automatic send(input logic [15:0] d);
    bit done;
    done       = 1'b0;
    load_valid = 1'b1;
    load_data  = d;
    for (int i = 0; i < 100 && !done; i++) begin
      done = !m_full;
      cycle();
    end
    load_valid = 1'b0;
    chk("send_accept", 16'(done), 16'h1);
  endtask

  task automatic model_reset();
    k = 0; m_disp = '0; m_pend = '0; m_full = 1'b0; m_lz = 1'b0; m_last = 4'h0;
  endtask

  initial begin
    bit acc;
    n_checks = 0; n_pass = 0; n_fail = 0;
    rst = 1'b1; load_valid = 1'b0; load_data = '0; lz_en = 1'b0;
    model_reset();

    // 1. reset state and free-running schedule
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    run(50);

    // 2. single load mid-frame
    send(16'h1A2F);
    run(45);

    // 3. back-to-back loads with valid held
    send(16'h1111);
    send(16'h2222);
    run(45);

    // 4. leading-zero suppression
    lz_en = 1'b1;
    send(16'h0050);
    run(45);
    send(16'h0000);
    run(45);
    lz_en = 1'b0;
    run(25);

    // 5. load presented exactly on the boundary cycle
    for (int i = 0; i < 40 && !fd(k); i++) cycle();
    chk("boundary_found", 16'(fd(k)), 16'h1);
    load_valid = 1'b1;
    load_data  = 16'hBEEF;
    cycle();
    load_valid = 1'b0;
    run(45);

    // 6. async reset mid-SHOW with a pending value
    for (int i = 0; i < 40 && !fd(k); i++) cycle();
    cycle();
    send(16'h1234);
    cycle();
    chk("in_show", 16'(show(k)), 16'h1);
    #2;
    rst = 1'b1;
    #1;
    load_valid = 1'b0;
    model_reset();
    check_outputs();
    @(negedge clk);
    rst = 1'b0;
    run(45);

    // 7. random loads and lz_en toggling
    for (int i = 0; i < 400; i++) begin
      if (!load_valid && $urandom_range(0, 3) == 0) begin
        load_valid = 1'b1;
        load_data  = 16'($urandom) >> $urandom_range(0, 16);
      end
      if ($urandom_range(0, 15) == 0) lz_en = ~lz_en;
      acc = load_valid && !m_full;
      cycle();
      if (acc) load_valid = 1'b0;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
